// File: rtl/instruction_scheduler_pkg.sv
// Shared types and constants for the instruction scheduler and its macro-op queue.
package instruction_scheduler_pkg;
  localparam int INSTR_W = 21;
  localparam logic [INSTR_W-1:0] NOP = '0;

  localparam logic [1:0] OP_ROTL = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_AUX  = 2'd3;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] p1;
    logic [5:0] p2;
  } mop_t;

  localparam int MOP_W = $bits(mop_t);
endpackage

// File: rtl/instruction_scheduler_fifo.sv
// Synchronous macro-op FIFO; registered storage, so a pushed entry is visible the cycle after.
module sched_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 14,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/instruction_scheduler.sv
// Runs one instruction unit at a time from a macro-op queue and gives the bus to a single registered owner.
module instruction_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 63,
  parameter int INSTR_W   = 21
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [1:0]                   cmd_op_i,
  input  logic [5:0]                   cmd_p1_i,
  input  logic [5:0]                   cmd_p2_i,
  output logic [NUM_UNITS-1:0]         unit_start_o,
  output logic [5:0]                   unit_p1_o,
  output logic [5:0]                   unit_p2_o,
  input  logic [NUM_UNITS-1:0]         unit_done_i,
  input  logic [NUM_UNITS*INSTR_W-1:0] unit_instr_i,
  output logic [INSTR_W-1:0]           instruction_o,
  output logic                         busy_o,
  output logic                         error_o,
  input  logic                         err_clr_i,
  output logic [15:0]                  ops_done_o
);
  import instruction_scheduler_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);

  state_e                             state;
  logic [1:0]                         active;
  logic [TW-1:0]                      timer;
  mop_t                               head, wr_mop;
  logic                               fifo_full, fifo_empty, pop;
  logic [AW:0]                        fifo_count;
  logic [NUM_UNITS-1:0][INSTR_W-1:0]  instr_arr;
  logic                               legal, done_act, timeout_hit, err_evt;

  assign wr_mop = '{op: cmd_op_i, p1: cmd_p1_i, p2: cmd_p2_i};

  sched_fifo #(.DEPTH(DEPTH), .W(MOP_W)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (cmd_valid_i),
    .pop   (pop),
    .wdata (wr_mop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready_o = ~fifo_full;
  assign busy_o      = (state == BUSY) || (fifo_count != '0);
  assign pop         = (state == IDLE) && !fifo_empty;
  assign legal       = int'(head.op) < NUM_UNITS;
  assign instr_arr   = unit_instr_i;
  assign done_act    = unit_done_i[active];
  assign timeout_hit = (timer == TW'(TIMEOUT));
  assign err_evt     = (pop && !legal) || ((state == BUSY) && !done_act && timeout_hit);

  // ownership follows the registered state, so the bus never has two drivers
  assign instruction_o = (state == BUSY) ? instr_arr[active] : INSTR_W'(NOP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      active       <= '0;
      timer        <= '0;
      unit_start_o <= '0;
      unit_p1_o    <= '0;
      unit_p2_o    <= '0;
      error_o      <= 1'b0;
      ops_done_o   <= '0;
    end else begin
      error_o      <= err_evt | (error_o & ~err_clr_i);
      unit_start_o <= '0;
      case (state)
        IDLE: begin
          if (pop && legal) begin
            state        <= BUSY;
            active       <= head.op;
            unit_p1_o    <= head.p1;
            unit_p2_o    <= head.p2;
            unit_start_o <= NUM_UNITS'(1) << head.op;
            timer        <= '0;
          end
        end
        BUSY: begin
          if (done_act) begin
            state      <= IDLE;
            ops_done_o <= ops_done_o + 16'd1;
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_scheduler.sv
// Directed bench for instruction_scheduler: behavioural unit models, a start/response scoreboard and a per-cycle monitor.
module tb_instruction_scheduler;
  localparam int NU = 4;
  localparam int TO = 63;
  localparam int IW = 21;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [1:0]       cmd_op_i = '0;
  logic [5:0]       cmd_p1_i = '0;
  logic [5:0]       cmd_p2_i = '0;
  logic [NU-1:0]    unit_start_o;
  logic [5:0]       unit_p1_o, unit_p2_o;
  logic [NU-1:0]    unit_done_i;
  logic [NU*IW-1:0] unit_instr_i;
  logic [IW-1:0]    instruction_o;
  logic             busy_o, error_o;
  logic             err_clr_i = 1'b0;
  logic [15:0]      ops_done_o;

  always #5 clk_i = ~clk_i;

  instruction_scheduler #(.NUM_UNITS(NU), .DEPTH(4), .TIMEOUT(TO), .INSTR_W(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_p1_i(cmd_p1_i), .cmd_p2_i(cmd_p2_i),
    .unit_start_o(unit_start_o), .unit_p1_o(unit_p1_o), .unit_p2_o(unit_p2_o),
    .unit_done_i(unit_done_i), .unit_instr_i(unit_instr_i),
    .instruction_o(instruction_o), .busy_o(busy_o), .error_o(error_o),
    .err_clr_i(err_clr_i), .ops_done_o(ops_done_o)
  );

  typedef struct {
    int unit; int p1; int p2;
    int acc;  // edge at which the push is accepted
    int lat;  // expected edges from acceptance to start, -1 = unchecked
    int gap;  // expected cycles from previous done to start, -1 = unchecked
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nerr = 0;
  int   cyc = 0;
  int   tcyc = 0;
  int   rel_cyc = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // unit models: done asserted dly[k] cycles after start (-1 = never), kick forces a one-cycle done
  int            dly [NU];
  int            cnt [NU];
  logic [NU-1:0] mdone = '0;
  logic [NU-1:0] kick = '0;
  assign unit_done_i = mdone | kick;

  always_comb begin
    unit_instr_i = '0;
    for (int k = 0; k < NU; k++)
      unit_instr_i[k*IW +: IW] = {2'(k + 1), 3'b000, tcyc[15:0]};
  end

  always begin
    @(posedge clk_i); #1;
    tcyc = tcyc + 1;
    for (int k = 0; k < NU; k++) begin
      if (!rst_ni) cnt[k] = -1;
      else if (unit_start_o[k]) cnt[k] = dly[k];
      else if (cnt[k] > 0) cnt[k] = cnt[k] - 1;
      mdone[k] = (cnt[k] == 0);
      if (cnt[k] == 0) cnt[k] = -1;
    end
  end

  // monitor: samples each cycle mid-period, pops the scoreboard on every start
  int owner = -1, ocnt = 0, ops_exp = 0, done_cyc = -100, rel = 0, op1 = 0, op2 = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      owner = -1; rel = 0; ops_exp = 0;
    end else begin
      if (rel != 0) begin
        if (rel == 1) ops_exp++;
        chk("ops_done", 32'(ops_done_o), ops_exp);
        if (rel == 2) chk("timeout_err", 32'(error_o), 1);
        rel_cyc = cyc;
        rel = 0;
      end
      if (unit_start_o != '0) begin
        if (sb.size() == 0) chk("unexpected_start", 32'(unit_start_o), 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("start_onehot", 32'(unit_start_o), 1 << e.unit);
          chk("start_p1", 32'(unit_p1_o), e.p1);
          chk("start_p2", 32'(unit_p2_o), e.p2);
          if (e.lat >= 0) chk("start_latency", cyc - e.acc, e.lat);
          if (e.gap >= 0) chk("start_gap", cyc - done_cyc, e.gap);
          owner = e.unit; ocnt = 0; op1 = e.p1; op2 = e.p2;
        end
      end else if (owner >= 0) ocnt++;
      chk("instr", 32'(instruction_o), (owner >= 0) ? 32'(unit_instr_i[owner*IW +: IW]) : 32'd0);
      if (owner >= 0) begin
        chk("p1_hold", 32'(unit_p1_o), op1);
        chk("p2_hold", 32'(unit_p2_o), op2);
        if (unit_done_i[owner]) begin rel = 1; done_cyc = cyc; owner = -1; end
        else if (ocnt == TO) begin rel = 2; owner = -1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic push(input int op, input int p1, input int p2, input int lat, input int gap,
                      output int waits);
    cmd_valid_i = 1'b1; cmd_op_i = 2'(op); cmd_p1_i = 6'(p1); cmd_p2_i = 6'(p2);
    waits = 0;
    while (!cmd_ready_o && waits < 200) begin tick(); waits++; end
    if (!cmd_ready_o) chk("push_accept", 32'(cmd_ready_o), 1);
    else sb.push_back(exp_t'{op, p1, p2, cyc + 1, lat, gap});
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    int n;
    n = 0;
    do begin @(negedge clk_i); #1; n++; end while (busy_o && n < 300);
    if (busy_o) chk("idle_timeout", 32'(busy_o), 0);
    c = cyc;
    tick();
  endtask

  int w, w0, w1, w2, w3, wx, ic;

  initial begin
    for (int k = 0; k < NU; k++) begin dly[k] = -1; cnt[k] = -1; end
    repeat (3) @(negedge clk_i);
    chk("rst_start", 32'(unit_start_o), 0);
    chk("rst_p1", 32'(unit_p1_o), 0);
    chk("rst_p2", 32'(unit_p2_o), 0);
    chk("rst_instr", 32'(instruction_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_ops", 32'(ops_done_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    tick(); rst_ni = 1'b1; tick();
    chk("rst_ready", 32'(cmd_ready_o), 1);

    // single rotate op, done 3 cycles after start
    dly[0] = 3;
    push(0, 16, 5, 1, -1, w);
    wait_idle(ic);
    chk("single_ops", 32'(ops_done_o), 1);
    chk("single_busy_fall", ic, rel_cyc);

    // back-to-back pushes on consecutive cycles
    dly[0] = 2; dly[1] = 1; dly[2] = 4;
    push(0, 1, 2, 1, -1, w0);
    push(1, 3, 4, -1, 2, w1);
    push(2, 5, 6, -1, 2, w2);
    push(0, 7, 8, -1, 2, w3);
    chk("b2b_ready_waits", w0 + w1 + w2 + w3, 0);
    wait_idle(ic);
    chk("b2b_ops", 32'(ops_done_o), 5);
    chk("b2b_busy_fall", ic, rel_cyc);

    // full queue behind a stalled unit 0
    dly[0] = -1; dly[1] = 1; dly[2] = 1; dly[3] = 1;
    push(0, 9, 9, 1, -1, w);
    push(1, 10, 1, -1, 2, w);
    push(2, 11, 2, -1, 2, w);
    push(3, 12, 3, -1, 2, w);
    push(1, 13, 4, -1, 2, w);
    chk("full_ready", 32'(cmd_ready_o), 0);
    chk("full_busy", 32'(busy_o), 1);
    fork
      push(2, 14, 5, -1, 2, wx);
      begin
        repeat (3) tick();
        chk("full_hold", 32'(cmd_ready_o), 0);
        kick[0] = 1'b1;
        tick();
        kick[0] = 1'b0;
      end
    join
    chk("extra_push_waits", wx, 5);
    wait_idle(ic);
    chk("full_ops", 32'(ops_done_o), 11);
    chk("full_no_err", 32'(error_o), 0);

    // spurious done from unit 2 while unit 1 runs
    dly[1] = 5;
    push(1, 20, 21, 1, -1, w);
    tick();
    kick[2] = 1'b1;
    tick();
    kick[2] = 1'b0;
    chk("spurious_busy", 32'(busy_o), 1);
    wait_idle(ic);
    chk("spurious_ops", 32'(ops_done_o), 12);

    // timeout on unit 3
    dly[3] = -1;
    push(3, 1, 2, 1, -1, w);
    wait_idle(ic);
    chk("timeout_ops", 32'(ops_done_o), 12);
    chk("timeout_sticky", 32'(error_o), 1);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("err_clr", 32'(error_o), 0);

    // reset in the second busy cycle with two ops queued
    dly[0] = -1;
    push(0, 3, 3, 1, -1, w);
    push(1, 4, 4, -1, -1, w);
    push(2, 5, 5, -1, -1, w);
    chk("pre_rst_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_start", 32'(unit_start_o), 0);
    chk("mid_rst_instr", 32'(instruction_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (6) tick();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_ops", 32'(ops_done_o), 0);
    chk("post_rst_ready", 32'(cmd_ready_o), 1);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
